// File: rtl/fifo_word_unpacker_pkg.sv
// Shared constants and types for the fifo word unpacker: fifo word width,
// lane-counter sizing helper and the two-state holding FSM encoding.
package fifo_word_unpacker_pkg;

   localparam int FIFO_DATA_W = 64;
   localparam int DEF_LANE_W  = 16;

   // Counter width for n lanes, never narrower than one bit so RATIO==1 still elaborates.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_RATIO = FIFO_DATA_W / DEF_LANE_W;

   typedef logic [clog2_min1(DEF_RATIO)-1:0] lane_cnt_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } unpack_state_t;

endpackage

// File: rtl/fifo_word_unpacker.sv
// Pops one wide word from a first-word-fall-through fifo and emits it as
// RATIO narrower lanes, LSB lane first, with valid/ready backpressure.
module fifo_word_unpacker
   import fifo_word_unpacker_pkg::*;
#(
   parameter int IN_WIDTH  = FIFO_DATA_W,
   parameter int OUT_WIDTH = DEF_LANE_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fifo_empty,
   input  logic [IN_WIDTH-1:0]  data_out,
   output logic                 r_ready,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_last,
   output logic [15:0]          words_done
);

   localparam int RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int CNT_W = clog2_min1(RATIO);
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

   generate
      if (IN_WIDTH % OUT_WIDTH != 0) begin : g_width_check
         $error("fifo_word_unpacker: IN_WIDTH must be a multiple of OUT_WIDTH");
      end
   endgenerate

   unpack_state_t        state_reg, state_next;
   logic [CNT_W-1:0]     lane_reg, lane_next;
   logic [IN_WIDTH-1:0]  word_reg, word_next;
   logic [15:0]          words_done_reg, words_done_next;

   logic held;
   logic last_lane;
   logic accept;
   logic drain;

   assign held      = (state_reg == ST_HOLD);
   assign last_lane = (lane_reg == LAST_LANE);
   assign accept    = held & out_ready;
   assign drain     = accept & last_lane;

   // Popping on the drain cycle refills the holding register with no bubble.
   assign r_ready = ~flush & ~fifo_empty & (~held | drain);

   assign out_valid  = held;
   assign out_last   = held & last_lane;
   assign out_data   = word_reg[int'(lane_reg)*OUT_WIDTH +: OUT_WIDTH];
   assign words_done = words_done_reg;

   always_comb begin
      state_next      = state_reg;
      lane_next       = lane_reg;
      word_next       = word_reg;
      words_done_next = words_done_reg;
      if (flush) begin
         state_next = ST_EMPTY;
         lane_next  = '0;
      end else begin
         case (state_reg)
            ST_EMPTY: begin
               if (r_ready) begin
                  word_next  = data_out;
                  lane_next  = '0;
                  state_next = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (accept && !last_lane) begin
                  lane_next = lane_reg + CNT_W'(1);
               end else if (drain) begin
                  words_done_next = words_done_reg + 16'd1;
                  lane_next       = '0;
                  if (r_ready) begin
                     word_next = data_out;
                  end else begin
                     state_next = ST_EMPTY;
                  end
               end
            end
            default: state_next = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_EMPTY;
         lane_reg       <= '0;
         word_reg       <= '0;
         words_done_reg <= '0;
      end else begin
         state_reg      <= state_next;
         lane_reg       <= lane_next;
         word_reg       <= word_next;
         words_done_reg <= words_done_next;
      end
   end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Directed and randomised bench for fifo_word_unpacker with a 4-deep
// behavioural fifo upstream and a lane-order scoreboard downstream.
module tb_fifo_word_unpacker;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty;
   logic [63:0] data_out;
   logic        r_ready;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_last;
   logic [15:0] words_done;

   // Upstream fifo model
   logic [63:0] fmem [4];
   logic [1:0]  rd_p, wr_p;
   logic [2:0]  cnt;
   logic        wr_req;
   logic [63:0] wr_data;

   // Scoreboard
   logic [63:0] exp_words [$];
   int          exp_lane;
   logic [15:0] exp_done;
   logic        mon_en;

   int n_cmp;
   int n_err;

   always #5 clk = ~clk;

   fifo_word_unpacker dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .data_out   (data_out),
      .r_ready    (r_ready),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .words_done (words_done)
   );

   assign fifo_empty = (cnt == 3'd0);
   assign data_out   = fmem[rd_p];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_p <= 2'd0;
         wr_p <= 2'd0;
         cnt  <= 3'd0;
      end else begin
         if (r_ready && cnt != 3'd0) rd_p <= rd_p + 2'd1;
         if (wr_req && cnt < 3'd4) begin
            fmem[wr_p] <= wr_data;
            wr_p       <= wr_p + 2'd1;
         end
         cnt <= cnt + 3'((wr_req && cnt < 3'd4) ? 1 : 0) - 3'((r_ready && cnt != 3'd0) ? 1 : 0);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      wr_req = 1'b0;
   endtask

   task automatic push1(input logic [63:0] w);
      wr_req  = 1'b1;
      wr_data = w;
      exp_words.push_back(w);
   endtask

   // Lane-order scoreboard and the never-pop-empty rule, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         check("r_ready_while_empty", 64'(r_ready & fifo_empty), 64'h0);
         if (mon_en && out_valid && out_ready) begin
            check("sb_nonempty", 64'(exp_words.size() != 0), 64'h1);
            if (exp_words.size() != 0) begin
               check("lane_data", 64'(out_data), 64'(exp_words[0][exp_lane*16 +: 16]));
               check("lane_last", 64'(out_last), 64'(exp_lane == 3));
               exp_lane++;
               if (exp_lane == 4) begin
                  exp_lane = 0;
                  void'(exp_words.pop_front());
                  exp_done = exp_done + 16'd1;
               end
            end
         end
      end
   end

   initial begin
      int pushed, lanes, pops, guard;
      logic started;
      logic [63:0] w;

      n_cmp = 0; n_err = 0;
      exp_lane = 0; exp_done = 16'd0; mon_en = 1'b0;
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0; wr_req = 1'b0; wr_data = 64'h0;

      // T1 reset
      tick(); tick();
      check("T1 r_ready", 64'(r_ready), 64'h0);
      check("T1 out_valid", 64'(out_valid), 64'h0);
      check("T1 words_done", 64'(words_done), 64'h0);
      check("T1 out_last", 64'(out_last), 64'h0);
      check("T1 out_data", 64'(out_data), 64'h0);
      rst = 1'b0;
      tick();
      check("T1 post r_ready", 64'(r_ready), 64'h0);
      check("T1 post out_valid", 64'(out_valid), 64'h0);

      // T2 single word
      mon_en = 1'b1; out_ready = 1'b1;
      push1(64'h4444_3333_2222_1111);
      tick();
      check("T2 pop", 64'(r_ready), 64'h1);
      check("T2 not yet valid", 64'(out_valid), 64'h0);
      tick();
      check("T2 lane0", 64'(out_data), 64'h1111);
      check("T2 lane0 valid", 64'(out_valid), 64'h1);
      check("T2 lane0 last", 64'(out_last), 64'h0);
      check("T2 no pop", 64'(r_ready), 64'h0);
      tick();
      check("T2 lane1", 64'(out_data), 64'h2222);
      tick();
      check("T2 lane2", 64'(out_data), 64'h3333);
      check("T2 lane2 last", 64'(out_last), 64'h0);
      tick();
      check("T2 lane3", 64'(out_data), 64'h4444);
      check("T2 lane3 last", 64'(out_last), 64'h1);
      tick();
      check("T2 idle", 64'(out_valid), 64'h0);
      check("T2 words_done", 64'(words_done), 64'd1);

      // T3 streaming 8 words
      pushed = 0; lanes = 0; pops = 0; guard = 0; started = 1'b0;
      while (lanes < 32 && guard < 400) begin
         if (pushed < 8 && cnt < 3'd4) begin
            w = {16'hA003 + 16'(pushed*4), 16'hA002 + 16'(pushed*4),
                 16'hA001 + 16'(pushed*4), 16'hA000 + 16'(pushed*4)};
            push1(w);
            pushed++;
         end
         #1;
         if (out_valid) started = 1'b1;
         if (started) check("T3 no gap", 64'(out_valid), 64'h1);
         if (r_ready) begin
            pops++;
            if (started) check("T3 pop on last", 64'(out_last & out_ready), 64'h1);
         end
         if (out_valid && out_ready) lanes++;
         tick();
         guard++;
      end
      check("T3 lanes", 64'(lanes), 64'd32);
      check("T3 pops", 64'(pops), 64'd8);
      check("T3 words_done", 64'(words_done), 64'd9);

      // T4 backpressure at lane 2
      push1(64'hDDDD_CCCC_BBBB_AAAA);
      tick();
      push1(64'h8888_7777_6666_5555);
      tick();
      check("T4 lane0", 64'(out_data), 64'hAAAA);
      tick();
      check("T4 lane1", 64'(out_data), 64'hBBBB);
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("T4 stall data", 64'(out_data), 64'hCCCC);
         check("T4 stall valid", 64'(out_valid), 64'h1);
         check("T4 stall r_ready", 64'(r_ready), 64'h0);
         tick();
      end
      out_ready = 1'b1;
      guard = 0;
      while (exp_words.size() != 0 && guard < 100) begin
         tick();
         guard++;
      end
      check("T4 drained", 64'(exp_words.size()), 64'd0);
      check("T4 words_done", 64'(words_done), 64'd11);

      // T5 flush while lane 1 showing
      mon_en = 1'b0;
      wr_req = 1'b1; wr_data = 64'hF004_F003_F002_F001;
      tick();
      wr_req = 1'b1; wr_data = 64'hA004_A003_A002_A001;
      tick();
      tick();
      check("T5 lane1", 64'(out_data), 64'hF002);
      flush = 1'b1;
      #1;
      check("T5 flush no pop", 64'(r_ready), 64'h0);
      tick();
      flush = 1'b0;
      #1;
      check("T5 valid dropped", 64'(out_valid), 64'h0);
      check("T5 words_done", 64'(words_done), 64'd11);
      check("T5 refill pop", 64'(r_ready), 64'h1);
      exp_words.push_back(64'hA004_A003_A002_A001);
      mon_en = 1'b1;
      tick();
      check("T5 restart lane0", 64'(out_data), 64'hA001);
      guard = 0;
      while (exp_words.size() != 0 && guard < 100) begin
         tick();
         guard++;
      end
      check("T5 words_done after", 64'(words_done), 64'd12);

      // T5b flush coinciding with last-lane accept
      mon_en = 1'b0;
      wr_req = 1'b1; wr_data = 64'h5004_5003_5002_5001;
      tick();
      repeat (4) tick();
      check("T5b lane3 last", 64'(out_last), 64'h1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      check("T5b words_done held", 64'(words_done), 64'd12);
      check("T5b valid dropped", 64'(out_valid), 64'h0);

      // T6 random backpressure and push gaps
      mon_en = 1'b1;
      pushed = 0; guard = 0;
      while ((pushed < 2000 || exp_words.size() != 0) && guard < 60000) begin
         out_ready = 1'($urandom_range(0, 1));
         if (pushed < 2000 && cnt < 3'd4 && $urandom_range(0, 1) == 1) begin
            push1({$urandom, $urandom});
            pushed++;
         end
         tick();
         guard++;
      end
      check("T6 drained", 64'(exp_words.size()), 64'd0);
      check("T6 words_done", 64'(words_done), 64'd2012);
      check("T6 sb count", 64'(words_done), 64'(exp_done));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
